// File: rtl/ecl_univ_counter.sv
// Universal up/down counter with MC10136 mode encoding, configurable width and modulus,
// synchronous clear and a registered wrap pulse. Active-low carry in/out for cascading.
module ecl_univ_counter #(
    parameter int unsigned      WIDTH       = 4,
    parameter longint unsigned  MODULUS     = 64'd1 << WIDTH,
    parameter longint unsigned  RESET_VALUE = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] d,
    input  logic             nci,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             nco,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ModeLoad = 2'd0,
        ModeDec  = 2'd1,
        ModeInc  = 2'd2,
        ModeHold = 2'd3
    } mode_e;

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= RstVal;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // Any unmatched (including unknown) mode falls through to hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else begin
            case (mode_e'(s))
                ModeLoad: q_d = (64'(d) < MODULUS) ? d : MaxVal;
                ModeInc: begin
                    if (!nci) begin
                        if (q_q == MaxVal) begin
                            q_d    = '0;
                            wrap_d = 1'b1;
                        end else begin
                            q_d = q_q + WIDTH'(1);
                        end
                    end
                end
                ModeDec: begin
                    if (!nci) begin
                        if (q_q == '0) begin
                            q_d    = MaxVal;
                            wrap_d = 1'b1;
                        end else begin
                            q_d = q_q - WIDTH'(1);
                        end
                    end
                end
                default: q_d = q_q;
            endcase
        end
    end

    // Carry-out ignores clr: it reflects the terminal count of the current q.
    always_comb begin
        nco = 1'b1;
        case (mode_e'(s))
            ModeInc: nco = !(!nci && (q_q == MaxVal));
            ModeDec: nco = !(!nci && (q_q == '0));
            default: nco = 1'b1;
        endcase
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_ecl_univ_counter.sv
// Directed bench for ecl_univ_counter: binary, decade, cascaded decade and async reset cases.
module tb_ecl_univ_counter;

    localparam logic [1:0] LOAD = 2'd0, DEC = 2'd1, INC = 2'd2, HOLD = 2'd3;

    logic clk, reset;
    int   n_total, n_bad;

    // binary counter: WIDTH=4, MODULUS=16, RESET_VALUE=0
    logic [1:0] s_a;   logic [3:0] d_a;  logic nci_a, clr_a;
    logic [3:0] q_a;   logic nco_a, wrap_a;
    // decade counter with RESET_VALUE=5
    logic [1:0] s_b;   logic [3:0] d_b;  logic nci_b, clr_b;
    logic [3:0] q_b;   logic nco_b, wrap_b;
    // two cascaded decade stages
    logic [1:0] s_c;   logic [3:0] d_c;  logic nci_c, clr_c;
    logic [3:0] q_lo, q_hi;  logic nco_lo, nco_hi, wrap_lo, wrap_hi;

    ecl_univ_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) u_bin (
        .clk(clk), .reset(reset), .s(s_a), .d(d_a), .nci(nci_a), .clr(clr_a),
        .q(q_a), .nco(nco_a), .wrap(wrap_a));

    ecl_univ_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(5)) u_dec (
        .clk(clk), .reset(reset), .s(s_b), .d(d_b), .nci(nci_b), .clr(clr_b),
        .q(q_b), .nco(nco_b), .wrap(wrap_b));

    ecl_univ_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_lo (
        .clk(clk), .reset(reset), .s(s_c), .d(d_c), .nci(nci_c), .clr(clr_c),
        .q(q_lo), .nco(nco_lo), .wrap(wrap_lo));

    ecl_univ_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_hi (
        .clk(clk), .reset(reset), .s(s_c), .d(d_c), .nci(nco_lo), .clr(clr_c),
        .q(q_hi), .nco(nco_hi), .wrap(wrap_hi));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset = 1'b1;
        s_a = HOLD; d_a = '0; nci_a = 1'b1; clr_a = 1'b0;
        s_b = HOLD; d_b = '0; nci_b = 1'b1; clr_b = 1'b0;
        s_c = HOLD; d_c = '0; nci_c = 1'b1; clr_c = 1'b0;
        step();
        chk("rst_q_a", q_a, 0);
        chk("rst_wrap_a", wrap_a, 0);
        chk("rst_nco_a", nco_a, 1);
        chk("rst_q_b", q_b, 5);
        reset = 1'b0;

        // binary: load ignores nci
        s_a = LOAD; d_a = 4'b0111; nci_a = 1'b1;
        step();
        chk("load_7", q_a, 7);
        chk("load_nco", nco_a, 1);

        // binary: increment through terminal count
        d_a = 4'b1110;
        step();
        chk("load_14", q_a, 14);
        s_a = INC; nci_a = 1'b0;
        #1 chk("inc_nco_14", nco_a, 1);
        step();
        chk("inc_q_15", q_a, 15);
        chk("inc_nco_15", nco_a, 0);
        chk("inc_wrap_pre", wrap_a, 0);
        step();
        chk("inc_wrap_q", q_a, 0);
        chk("inc_wrap_pulse", wrap_a, 1);
        chk("inc_nco_0", nco_a, 1);
        step();
        chk("inc_q_1", q_a, 1);
        chk("inc_wrap_end", wrap_a, 0);
        nci_a = 1'b1;
        step();
        chk("inc_nci_hold", q_a, 1);

        // binary: decrement through zero
        s_a = LOAD; d_a = 4'b0011;
        step();
        s_a = DEC; nci_a = 1'b0;
        step();
        chk("dec_q_2", q_a, 2);
        step();
        chk("dec_q_1", q_a, 1);
        step();
        chk("dec_q_0", q_a, 0);
        chk("dec_nco_0", nco_a, 0);
        step();
        chk("dec_wrap_q", q_a, 15);
        chk("dec_wrap_pulse", wrap_a, 1);
        chk("dec_nco_15", nco_a, 1);
        s_a = HOLD;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_q", q_a, 15);
            chk("hold_nco", nco_a, 1);
            chk("hold_wrap", wrap_a, 0);
        end
        s_a = LOAD; nci_a = 1'b0; d_a = 4'b1111;
        #1 chk("load_nco_nci0", nco_a, 1);

        // clear beats load
        clr_a = 1'b1; d_a = 4'b0101;
        step();
        chk("clr_load", q_a, 0);
        clr_a = 1'b0; s_a = HOLD;

        // decade: clamp, wrap up, wrap down
        s_b = LOAD; d_b = 4'b1100;
        step();
        chk("dec10_clamp", q_b, 9);
        s_b = INC; nci_b = 1'b0;
        #1 chk("dec10_nco_9", nco_b, 0);
        step();
        chk("dec10_inc_q", q_b, 0);
        chk("dec10_inc_wrap", wrap_b, 1);
        s_b = DEC;
        step();
        chk("dec10_dec_q", q_b, 9);
        chk("dec10_dec_wrap", wrap_b, 1);
        s_b = LOAD; d_b = 4'b1000;
        step();
        chk("dec10_load_8", q_b, 8);

        // cascaded decade chain 00..99
        clr_c = 1'b1;
        step();
        chk("casc_clr", {q_hi, q_lo}, 8'h00);
        clr_c = 1'b0; s_c = INC; nci_c = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("casc_09", {q_hi, q_lo}, 8'h09);
        chk("casc_09_nco_lo", nco_lo, 0);
        chk("casc_09_nco_hi", nco_hi, 1);
        step();
        chk("casc_10", {q_hi, q_lo}, 8'h10);
        for (int i = 0; i < 89; i++) step();
        chk("casc_99", {q_hi, q_lo}, 8'h99);
        chk("casc_99_nco_hi", nco_hi, 0);
        step();
        chk("casc_00", {q_hi, q_lo}, 8'h00);
        chk("casc_wrap_hi", wrap_hi, 1);
        s_c = HOLD;

        // asynchronous reset mid-count on the decade counter
        s_b = INC; nci_b = 1'b0;
        step();
        chk("async_pre_q", q_b, 9);
        step();
        chk("async_pre_wrap", wrap_b, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_q", q_b, 5);
        chk("async_wrap", wrap_b, 0);
        chk("async_q_a", q_a, 0);
        step();
        reset = 1'b0;
        step();
        chk("async_resume", q_b, 6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
